// File: rtl/game_pkg.sv
// Shared types and defaults for the game-state controller: state encoding,
// parameter defaults and the obstacle-pass popcount helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } game_state_e;

  localparam int N_OBS_DEF       = 5;
  localparam int WRAP_THRESH_DEF = 400;
  localparam int SCORE_MAX_DEF   = 99;
  localparam int DIV_INIT_DEF    = 500000;
  localparam int DIV_STEP_DEF    = 50000;
  localparam int DIV_MIN_DEF     = 100000;
  localparam int LEVEL_PTS_DEF   = 10;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Frame-level bundle between the sprite/obstacle stages and the game controller:
// per-pixel drawing flags, obstacle positions, keys and the game outputs.
interface game_controller_if #(
  parameter int N_OBS = game_pkg::N_OBS_DEF
);
  logic                  vsync;
  logic                  start_n;
  logic                  player_drawing;
  logic [N_OBS-1:0]      obstacle_drawing;
  logic [N_OBS*10-1:0]   obstacle_y;
  logic                  playing;
  logic                  game_over;
  logic [6:0]            score;
  logic [6:0]            max_score;
  logic [31:0]           divider;

  modport master (
    output vsync, start_n, player_drawing, obstacle_drawing, obstacle_y,
    input  playing, game_over, score, max_score, divider
  );

  modport slave (
    input  vsync, start_n, player_drawing, obstacle_drawing, obstacle_y,
    output playing, game_over, score, max_score, divider
  );
endinterface

// File: rtl/obstacle_pass_detect.sv
// Per-obstacle wrap detector: remembers the Y seen on the previous frame tick
// and flags a pass when the obstacle jumps back up from near the bottom.
module obstacle_pass_detect
  import game_pkg::*;
#(
  parameter int WRAP_THRESH = WRAP_THRESH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] y,
  output logic       pass
);

  localparam logic [9:0] THRESH_C = 10'(WRAP_THRESH);

  logic [9:0] prev_y_r;
  logic       pass_s;

  // Track last frame's Y, refreshed on every tick regardless of game state.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_y_r <= 10'd0;
    end else if (tick) begin
      prev_y_r <= y;
    end else begin
      prev_y_r <= prev_y_r;
    end
  end

  // A pass is a drop in Y from at or below the wrap line, qualified by tick.
  always_comb begin
    pass_s = 1'b0;
    if (tick) begin
      pass_s = (prev_y_r >= THRESH_C) && (y < prev_y_r);
    end else begin
      pass_s = 1'b0;
    end
  end

  assign pass = pass_s;

endmodule

// File: rtl/game_controller.sv
// Game-state controller: start-key sync, frame tick, collision latch, IDLE/PLAYING/OVER
// FSM, saturating score, best score and game-speed divider (no extra divider latency).
module game_controller
  import game_pkg::*;
#(
  parameter int N_OBS       = N_OBS_DEF,
  parameter int WRAP_THRESH = WRAP_THRESH_DEF,
  parameter int SCORE_MAX   = SCORE_MAX_DEF,
  parameter int DIV_INIT    = DIV_INIT_DEF,
  parameter int DIV_STEP    = DIV_STEP_DEF,
  parameter int DIV_MIN     = DIV_MIN_DEF,
  parameter int LEVEL_PTS   = LEVEL_PTS_DEF
) (
  input logic               CLOCK_50,
  input logic               reset,
  game_controller_if.slave  bus
);

  localparam logic [6:0]  SCORE_MAX_C = 7'(SCORE_MAX);
  localparam logic [6:0]  LEVEL_PTS_C = 7'(LEVEL_PTS);
  localparam logic [31:0] DIV_INIT_C  = 32'(DIV_INIT);
  localparam logic [31:0] DIV_STEP_C  = 32'(DIV_STEP);
  localparam logic [31:0] DIV_MIN_C   = 32'(DIV_MIN);

  logic              s1_r, s2_r, s3_r, press_r;
  logic              vs_d_r, tick_s, collide_s;
  logic [N_OBS-1:0]  pass_s;
  logic [4:0]        pass5_s;
  logic [2:0]        n_pass_s;

  game_state_e       state_r, state_nxt_s;
  logic              hit_r, hit_nxt_s;
  logic [6:0]        score_r, score_nxt_s;
  logic [6:0]        max_score_r, max_nxt_s;
  logic [6:0]        level_r, level_nxt_s;
  logic [31:0]       divider_r, div_nxt_s;
  logic              playing_r, game_over_r;

  logic [7:0]        sum_s;
  logic [6:0]        sat_s, new_level_s, lvl_delta_s;
  logic [31:0]       dec_s, div_step_s;

  // Start key: 2-FF synchronizer, delay stage and a registered one-cycle press pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_r    <= 1'b1;
      s2_r    <= 1'b1;
      s3_r    <= 1'b1;
      press_r <= 1'b0;
      vs_d_r  <= 1'b0;
    end else begin
      s1_r    <= bus.start_n;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      press_r <= s3_r & ~s2_r;
      vs_d_r  <= bus.vsync;
    end
  end

  assign tick_s    = vs_d_r & ~bus.vsync;
  assign collide_s = bus.player_drawing & (|bus.obstacle_drawing);

  genvar gi;
  generate
    for (gi = 0; gi < N_OBS; gi++) begin : g_obs
      obstacle_pass_detect #(
        .WRAP_THRESH (WRAP_THRESH)
      ) u_pass (
        .clk   (CLOCK_50),
        .reset (reset),
        .tick  (tick_s),
        .y     (bus.obstacle_y[10*gi +: 10]),
        .pass  (pass_s[gi])
      );
    end
  endgenerate

  assign pass5_s  = 5'(pass_s);
  assign n_pass_s = popcount5(pass5_s);

  // Saturating score and speed-level arithmetic for a clean (hit-free) tick.
  always_comb begin
    sum_s       = {1'b0, score_r} + {5'd0, n_pass_s};
    sat_s       = (sum_s > {1'b0, SCORE_MAX_C}) ? SCORE_MAX_C : sum_s[6:0];
    new_level_s = sat_s / LEVEL_PTS_C;
    lvl_delta_s = new_level_s - level_r;
    dec_s       = 32'(lvl_delta_s) * DIV_STEP_C;
    if (dec_s == 32'd0) begin
      div_step_s = divider_r;
    end else if (divider_r >= (DIV_MIN_C + dec_s)) begin
      div_step_s = divider_r - dec_s;
    end else begin
      div_step_s = DIV_MIN_C;
    end
  end

  // Next-state logic; a press in IDLE/OVER takes priority over a coincident tick.
  always_comb begin
    state_nxt_s = state_r;
    score_nxt_s = score_r;
    max_nxt_s   = max_score_r;
    level_nxt_s = level_r;
    div_nxt_s   = divider_r;
    if (tick_s) begin
      hit_nxt_s = 1'b0;
    end else if (collide_s) begin
      hit_nxt_s = 1'b1;
    end else begin
      hit_nxt_s = hit_r;
    end
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (press_r) begin
          state_nxt_s = ST_PLAYING;
          score_nxt_s = 7'd0;
          hit_nxt_s   = 1'b0;
          level_nxt_s = 7'd0;
          div_nxt_s   = DIV_INIT_C;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PLAYING: begin
        if (tick_s && hit_r) begin
          state_nxt_s = ST_OVER;
          max_nxt_s   = (score_r > max_score_r) ? score_r : max_score_r;
        end else if (tick_s) begin
          score_nxt_s = sat_s;
          level_nxt_s = new_level_s;
          div_nxt_s   = div_step_s;
        end else begin
          state_nxt_s = ST_PLAYING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Game state, scores, divider and decoded status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      hit_r       <= 1'b0;
      score_r     <= 7'd0;
      max_score_r <= 7'd0;
      level_r     <= 7'd0;
      divider_r   <= DIV_INIT_C;
      playing_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hit_r       <= hit_nxt_s;
      score_r     <= score_nxt_s;
      max_score_r <= max_nxt_s;
      level_r     <= level_nxt_s;
      divider_r   <= div_nxt_s;
      playing_r   <= (state_nxt_s == ST_PLAYING);
      game_over_r <= (state_nxt_s == ST_OVER);
    end
  end

  assign bus.playing   = playing_r;
  assign bus.game_over = game_over_r;
  assign bus.score     = score_r;
  assign bus.max_score = max_score_r;
  assign bus.divider   = divider_r;

endmodule
